// File: rtl/ram_req_adapter.sv
// ram_req_adapter: valid/ready front end for a single-port synchronous-read,
// byte-enable-write block RAM. Requests drive the RAM pins combinationally.
// The one-cycle read data (or 0 for writes) is captured into a circular
// response queue, so responses survive back-pressure on the response side.
// Optional feature macro: RAM_REQ_ADAPTER_BYPASS_EN. When it is defined, the
// in-flight result is presented combinationally while the queue is empty.
// In the default build every response comes from the registered queue.
module ram_req_adapter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic                    o_resp_write,
    output logic [DATA_WIDTH-1:0]   o_resp_rdata,
    output logic [ADDR_WIDTH-1:0]   o_ram_raddr,
    output logic [ADDR_WIDTH-1:0]   o_ram_waddr,
    output logic [DATA_WIDTH/8-1:0] o_ram_wstrb,
    output logic [DATA_WIDTH-1:0]   o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]   i_ram_rdata
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic                  r_rdy_en;
    logic                  r_inflight;
    logic                  r_infl_wr;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [DATA_WIDTH-1:0] r_qdata [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] r_qwr;

    logic                  w_fire;
    logic [CW:0]           w_used;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  w_qvalid;
    logic                  w_qpop;
    logic                  w_push;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit: queue slots plus the in-flight slot must leave room for a new
    // request. Nothing from the response side feeds this path.
    assign w_used      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign o_req_ready = r_rdy_en && (w_used < (CW+1)'(RESP_DEPTH));
    assign w_fire      = i_req_valid && o_req_ready;

    assign o_ram_raddr = i_req_addr;
    assign o_ram_waddr = i_req_addr;
    assign o_ram_wdata = i_req_wdata;
    assign o_ram_wstrb = (w_fire && i_req_write) ? i_req_wstrb : '0;

    assign w_ret_data  = r_infl_wr ? '0 : i_ram_rdata;
    assign w_qvalid    = (r_count != '0);
    assign w_qpop      = w_qvalid && i_resp_ready;

`ifdef RAM_REQ_ADAPTER_BYPASS_EN
    logic w_byp;
    assign w_byp = r_inflight && !w_qvalid;
    // Empty queue: present the retiring entry directly; it skips the queue
    // only when it is consumed this cycle.
    always_comb begin
        o_resp_valid = w_qvalid || w_byp;
        o_resp_write = 1'b0;
        o_resp_rdata = '0;
        if (w_qvalid) begin
            o_resp_write = r_qwr[r_head];
            o_resp_rdata = r_qdata[r_head];
        end else if (w_byp) begin
            o_resp_write = r_infl_wr;
            o_resp_rdata = w_ret_data;
        end
    end
    assign w_push = r_inflight && !(w_byp && i_resp_ready);
`else
    // Responses come straight from queue registers; zero when empty.
    always_comb begin
        o_resp_valid = w_qvalid;
        o_resp_write = w_qvalid && r_qwr[r_head];
        o_resp_rdata = w_qvalid ? r_qdata[r_head] : '0;
    end
    assign w_push = r_inflight;
`endif

    // Ready enable: held low through reset, rises on the first edge after.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    // In-flight tracker: set on fire, retires into the queue one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= 1'b0;
            r_infl_wr  <= 1'b0;
        end else begin
            r_inflight <= w_fire;
            r_infl_wr  <= w_fire && i_req_write;
        end
    end

    // Response queue: circular buffer with push at tail, pop at head.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_qwr   <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) r_qdata[i] <= '0;
        end else begin
            if (w_push) begin
                r_qdata[r_tail] <= w_ret_data;
                r_qwr[r_tail]   <= r_infl_wr;
                r_tail          <= f_next(r_tail);
            end
            if (w_qpop) r_head <= f_next(r_head);
            case ({w_push, w_qpop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_req_adapter.sv
// Self-checking bench for ram_req_adapter: behavioural RAM, reference memory
// and an in-order scoreboard of expected responses.
module tb_ram_req_adapter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW/8;
    localparam int DEPTH = 3;
`ifdef RAM_REQ_ADAPTER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          resp_ready = 1'b1;
    logic          req_ready, resp_valid, resp_write;
    logic [DW-1:0] resp_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [SW-1:0] ram_wstrb;

    ram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_write(resp_write), .o_resp_rdata(resp_rdata),
        .o_ram_raddr(ram_raddr), .o_ram_waddr(ram_waddr),
        .o_ram_wstrb(ram_wstrb), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [DW-1:0] d; } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ram_mem [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_resp = 0;
    int            last_rd_cyc = 0;
    logic [DW-1:0] last_rd_data = '0;
    logic [DW-1:0] last_wr_rdata = '0;

    initial begin
        for (int i = 0; i < (1<<AW); i++) begin
            ram_mem[i] = 32'hA5000000 ^ (i * 32'h00010101);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010101);
        end
    end

    // Behavioural synchronous-read RAM with byte-enable write.
    always @(posedge clk) begin
        for (int b = 0; b < SW; b++)
            if (ram_wstrb[b]) ram_mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram_mem[ram_raddr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: request fire pushes the reference result; response pops it.
    always @(negedge clk) begin
        logic          fire;
        logic [SW-1:0] exp_strb;
        exp_t          e;
        fire = req_valid && req_ready;
        exp_strb = (fire && req_write) ? req_wstrb : '0;
        n_cmp++;
        if (ram_wstrb !== exp_strb) begin
            n_err++;
            $display("FAIL wstrb cyc=%0d got=%h want=%h", cyc, ram_wstrb, exp_strb);
        end
        if (fire) begin
            if (req_write) begin
                for (int b = 0; b < SW; b++)
                    if (req_wstrb[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                e.w = 1'b1; e.d = '0;
            end else begin
                e.w = 1'b0; e.d = ref_mem[req_addr];
            end
            sb.push_back(e);
        end
        if (resp_valid && resp_ready) begin
            n_resp++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected cyc=%0d got w=%b d=%h want none", cyc, resp_write, resp_rdata);
            end else begin
                e = sb.pop_front();
                if (resp_write !== e.w || resp_rdata !== e.d) begin
                    n_err++;
                    $display("FAIL resp_data cyc=%0d got w=%b d=%h want w=%b d=%h",
                             cyc, resp_write, resp_rdata, e.w, e.d);
                end
            end
            if (resp_write) last_wr_rdata = resp_rdata;
            else begin last_rd_cyc = cyc; last_rd_data = resp_rdata; end
        end
    end

    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int fc);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        fc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin fc = cyc; break; end
        end
        @(posedge clk); #1;
        if (fc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout got no accept want accept within 200 cycles");
        end
    endtask

    task automatic idle();
        req_valid = 1'b0; req_write = 1'b0; req_wstrb = '0;
    endtask

    task automatic wait_drain();
        resp_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain got pending=%0d valid=%b want 0/0", sb.size(), resp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_write !== 1'b0 ||
            resp_rdata !== '0 || ram_wstrb !== '0) begin
            n_err++;
            $display("FAIL reset_vals got rdy=%b v=%b w=%b d=%h s=%h want 0", req_ready,
                     resp_valid, resp_write, resp_rdata, ram_wstrb);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_basic_rw();
        int fw, fr;
        do_req(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, fw);
        do_req(1'b0, 12'h010, '0, '0, fr);
        idle();
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (last_rd_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL raw_data got %h want deadbeef", last_rd_data);
        end
        n_cmp++;
        if (last_rd_cyc - fr != LAT) begin
            n_err++; $display("FAIL raw_latency got %0d want %0d", last_rd_cyc - fr, LAT);
        end
        n_cmp++;
        if (fr - fw != 1) begin
            n_err++; $display("FAIL raw_b2b got gap %0d want 1", fr - fw);
        end
    endtask

    task automatic test_partial_write();
        int f;
        do_req(1'b1, 12'h020, 32'h11223344, 4'hF, f);
        do_req(1'b1, 12'h020, 32'h0000AB00, 4'h2, f);
        do_req(1'b0, 12'h020, '0, '0, f);
        idle();
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (last_rd_data !== 32'h1122AB44) begin
            n_err++; $display("FAIL partial_data got %h want 1122ab44", last_rd_data);
        end
        n_cmp++;
        if (last_wr_rdata !== '0) begin
            n_err++; $display("FAIL partial_wresp got %h want 0", last_wr_rdata);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int r0, f;
        logic [AW-1:0] a = 12'h100;
        logic fired;
        r0 = n_resp;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fired = req_ready;
            if (fired) acc++;
            @(posedge clk); #1;
            if (fired) begin a = a + 1'b1; req_addr = a; end
        end
        n_cmp++;
        if (acc != DEPTH) begin
            n_err++; $display("FAIL bp_accepted got %0d want %0d", acc, DEPTH);
        end
        n_cmp++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_stall got rdy=%b v=%b want 0/1", req_ready, resp_valid);
        end
        resp_ready = 1'b1;
        for (int i = acc; i < 5; i++) begin
            do_req(1'b0, a, '0, '0, f);
            a = a + 1'b1;
        end
        idle();
        wait_drain();
        n_cmp++;
        if (n_resp - r0 != 5) begin
            n_err++; $display("FAIL bp_count got %0d want 5", n_resp - r0);
        end
    endtask

    task automatic test_stream();
        int nf = 0, nr = 0, ff = -1, lf = -1, fr = -1, lr = -1;
        logic fired;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
        for (int i = 0; i < 60 && nr < 16; i++) begin
            @(negedge clk);
            fired = req_valid && req_ready;
            if (fired) begin nf++; if (ff < 0) ff = cyc; lf = cyc; end
            if (resp_valid) begin nr++; if (fr < 0) fr = cyc; lr = cyc; end
            @(posedge clk); #1;
            if (fired) begin
                req_addr = req_addr + 1'b1;
                if (nf == 16) req_valid = 1'b0;
            end
        end
        idle();
        n_cmp++;
        if (nf != 16 || lf - ff != 15) begin
            n_err++; $display("FAIL stream_accept got n=%0d span=%0d want 16/15", nf, lf - ff);
        end
        n_cmp++;
        if (nr != 16 || lr - fr != 15 || fr - ff != LAT) begin
            n_err++; $display("FAIL stream_resp got n=%0d span=%0d lat=%0d want 16/15/%0d",
                              nr, lr - fr, fr - ff, LAT);
        end
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        int f;
        int bad = 0;
        resp_ready = 1'b0;
        do_req(1'b0, 12'h200, '0, '0, f);
        do_req(1'b0, 12'h201, '0, '0, f);
        do_req(1'b0, 12'h202, '0, '0, f);
        idle();
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_valid got %b want 1", resp_valid);
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid got v=%b rdy=%b want 0/0", resp_valid, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_ready got %b want 1", req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rst_stale got %0d stale cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        int f;
        int r0;
        logic done = 1'b0;
        r0 = n_resp;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) begin idle(); @(posedge clk); #1; end
                    do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                           SW'($urandom_range(0, 15)), f);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain();
        n_cmp++;
        if (n_resp - r0 != 1000) begin
            n_err++; $display("FAIL random_count got %0d want 1000", n_resp - r0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_partial_write();
        test_backpressure();
        test_stream();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
